// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the execute-stage multiply/divide unit: the MDOp
// encoding (also used by the decoder and the stall unit), the sequencer
// state type and small op-classification helpers.
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

   localparam int unsigned MD_OP_W = 4;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // True for the four multi-cycle operations that raise Start.
   function automatic logic is_start_op(input logic [MD_OP_W-1:0] op);
      logic r;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // True for the two division operations (they use the longer latency).
   function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
      logic r;
      case (op)
         MD_DIV, MD_DIVU: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Bundles the E-stage operation/operand inputs and the unit's result/status
// outputs.
//   master : E-stage side, drives MDOpE/SrcAE/SrcBE, observes the rest
//   slave  : the multiply/divide unit
// ---------------------------------------------------------------------------
interface mult_div_unit_if;
   logic [3:0]  MDOpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDOutE;

   modport master (
      output MDOpE, SrcAE, SrcBE,
      input  Start, Busy, HI, LO, MDOutE
   );

   modport slave (
      input  MDOpE, SrcAE, SrcBE,
      output Start, Busy, HI, LO, MDOutE
   );
endinterface

// File: rtl/mult_div_unit_md_arith.sv
// ---------------------------------------------------------------------------
// md_arith
// Combinational arithmetic core. Maps op + operands to a 64-bit {hi,lo}
// result and flags a zero divisor for div/divu.
//   op          : MDOp code
//   a, b        : rs / rt operands
//   result      : {hi, lo}; product for mult(u), {remainder, quotient} for div(u)
//   div_by_zero : 1 when op is div/divu and b == 0
// ---------------------------------------------------------------------------
module md_arith
   import mult_div_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic        is_signed_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [63:0] ext_a_s;
   logic [63:0] ext_b_s;
   logic [63:0] prod_s;
   logic [31:0] dividend_s;
   logic [31:0] divisor_s;
   logic [31:0] q_mag_s;
   logic [31:0] r_mag_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;

   // Operand conditioning shared by the single multiplier and single divider.
   always_comb begin
      is_signed_s = (op == MD_MULT) || (op == MD_DIV);
      a_neg_s     = is_signed_s & a[31];
      b_neg_s     = is_signed_s & b[31];
      // Sign-extending to 64 bits lets one unsigned multiplier serve both
      // mult and multu: the low 64 bits are correct modulo 2^64.
      ext_a_s     = a_neg_s ? {32'hFFFF_FFFF, a} : {32'h0000_0000, a};
      ext_b_s     = b_neg_s ? {32'hFFFF_FFFF, b} : {32'h0000_0000, b};
      prod_s      = ext_a_s * ext_b_s;
      // Divide magnitudes, then restore signs; this makes the
      // 0x80000000 / -1 overflow fall out as 0x80000000 rem 0.
      dividend_s  = a_neg_s ? (32'd0 - a) : a;
      // Substitute 1 for a zero divisor so the divider never sees /0;
      // the result is discarded in that case anyway.
      if (b == 32'd0) begin
         divisor_s = 32'd1;
      end else begin
         divisor_s = b_neg_s ? (32'd0 - b) : b;
      end
      q_mag_s     = dividend_s / divisor_s;
      r_mag_s     = dividend_s % divisor_s;
      quot_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
      rem_s       = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
   end

   // Result selection by operation.
   always_comb begin
      result      = 64'd0;
      div_by_zero = 1'b0;
      case (op)
         MD_MULT, MD_MULTU: begin
            result = prod_s;
         end
         MD_DIV, MD_DIVU: begin
            result      = {rem_s, quot_s};
            div_by_zero = (b == 32'd0);
         end
         default: begin
            result = 64'd0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Execute-stage multiply/divide unit holding the HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   md (slave) : MDOpE/SrcAE/SrcBE in; Start (comb), Busy (reg),
//                HI/LO (reg), MDOutE (comb, mfhi/mflo read data) out
// A mult/div is accepted when Start is high and the unit is idle; the result
// is computed immediately into temporaries and committed to HI/LO when the
// countdown expires, so Busy is high for exactly MULT_CYCLES / DIV_CYCLES.
// ---------------------------------------------------------------------------
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
)(
   input  logic            clk,
   input  logic            reset,
   mult_div_unit_if.slave  md
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e          state_r;
   md_state_e          state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [31:0]        hi_r;
   logic [31:0]        lo_r;
   logic [31:0]        tmp_hi_r;
   logic [31:0]        tmp_lo_r;
   logic               tmp_dbz_r;
   logic               start_s;
   logic               accept_s;
   logic               done_s;
   logic [63:0]        arith_res_s;
   logic               arith_dbz_s;

   md_arith u_arith (
      .op          (md.MDOpE),
      .a           (md.SrcAE),
      .b           (md.SrcBE),
      .result      (arith_res_s),
      .div_by_zero (arith_dbz_s)
   );

   assign start_s  = is_start_op(md.MDOpE);
   assign md.Start = start_s;
   assign md.Busy  = (state_r == ST_BUSY);
   assign md.HI    = hi_r;
   assign md.LO    = lo_r;

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic with accept and completion strobes.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s  = ST_BUSY;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == CNT_W'(1)) begin
               state_s = ST_IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = ST_BUSY;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Countdown and result temporaries, captured from the accept-edge operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= '0;
         tmp_hi_r  <= 32'd0;
         tmp_lo_r  <= 32'd0;
         tmp_dbz_r <= 1'b0;
      end else if (accept_s) begin
         cnt_r     <= is_div_op(md.MDOpE) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         tmp_hi_r  <= arith_res_s[63:32];
         tmp_lo_r  <= arith_res_s[31:0];
         tmp_dbz_r <= arith_dbz_s;
      end else if (cnt_r != '0) begin
         cnt_r     <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r     <= cnt_r;
      end
   end

   // Architectural HI/LO: committed on completion, or written by mthi/mtlo
   // when idle. A zero-divisor division completes without touching them.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else if (done_s) begin
         if (!tmp_dbz_r) begin
            hi_r <= tmp_hi_r;
            lo_r <= tmp_lo_r;
         end
      end else if (state_r == ST_IDLE) begin
         if (md.MDOpE == MD_MTHI) begin
            hi_r <= md.SrcAE;
         end
         if (md.MDOpE == MD_MTLO) begin
            lo_r <= md.SrcAE;
         end
      end
   end

   // mfhi/mflo read port; zero for every other op.
   always_comb begin
      md.MDOutE = 32'd0;
      case (md.MDOpE)
         MD_MFHI: md.MDOutE = hi_r;
         MD_MFLO: md.MDOutE = lo_r;
         default: md.MDOutE = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench: each accepted mult/div pushes its expected HI/LO and Busy
// length; a monitor pops and compares when Busy falls. Expected values come
// from plain 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_div_unit_if md_if();

   mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_if.slave)
   );

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: HI/LO after the op, using 64-bit integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, uq, ur;
      ia = a; ib = b; sa = ia; sb = ib;
      ua = {32'd0, a}; ub = {32'd0, b};
      case (op)
         MD_MULT:  begin q = sa * sb; return q; end
         MD_MULTU: return ua * ub;
         MD_DIV: begin
            if (b == 32'd0) return {m_hi, m_lo};
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         MD_DIVU: begin
            if (b == 32'd0) return {m_hi, m_lo};
            uq = ua / ub; ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: return {m_hi, m_lo};
      endcase
   endfunction

   // Issue one mult/div; assumes the unit is idle (called at posedge+1).
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] r;
      r        = ref_result(op, a, b);
      e.hi     = r[63:32];
      e.lo     = r[31:0];
      e.cycles = ((op == MD_DIV) || (op == MD_DIVU)) ? DIV_N : MULT_N;
      sb_q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
      md_if.MDOpE = op; md_if.SrcAE = a; md_if.SrcBE = b;
      #1 check32("start_on_issue", {31'd0, md_if.Start}, 32'd1);
      @(posedge clk); #1;
      md_if.MDOpE = MD_NONE; md_if.SrcAE = $urandom; md_if.SrcBE = $urandom;
      check32("busy_after_accept", {31'd0, md_if.Busy}, 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk); #1;
         if (md_if.Busy === 1'b0) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wait_idle: Busy still high after 40 cycles, required low");
      end
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      md_if.MDOpE = op; md_if.SrcAE = v; md_if.SrcBE = $urandom;
      @(posedge clk); #1;
      md_if.MDOpE = MD_NONE;
      if (op == MD_MTHI) m_hi = v; else m_lo = v;
      check32("mt_hi", md_if.HI, m_hi);
      check32("mt_lo", md_if.LO, m_lo);
   endtask

   task automatic mf(input logic [3:0] op);
      md_if.MDOpE = op;
      #1 check32("mf_out", md_if.MDOutE, (op == MD_MFHI) ? m_hi : m_lo);
      md_if.MDOpE = MD_NONE;
      @(posedge clk); #1;
   endtask

   task automatic noop(input logic [3:0] op);
      md_if.MDOpE = op; md_if.SrcAE = $urandom; md_if.SrcBE = $urandom;
      #1;
      check32("noop_start", {31'd0, md_if.Start}, 32'd0);
      check32("noop_mdout", md_if.MDOutE, 32'd0);
      @(posedge clk); #1;
      md_if.MDOpE = MD_NONE;
      check32("noop_hi", md_if.HI, m_hi);
      check32("noop_lo", md_if.LO, m_lo);
   endtask

   // Monitor: count Busy cycles; on the falling edge of Busy pop and compare.
   int   busy_cnt   = 0;
   logic prev_busy  = 1'b0;
   logic prev_reset = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (md_if.Busy === 1'b1) begin
         busy_cnt++;
      end else if (prev_busy) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: Busy fell with no expected result queued");
         end else begin
            e = sb_q.pop_front();
            if (prev_reset) begin
               check32("abort_hi", md_if.HI, 32'd0);
               check32("abort_lo", md_if.LO, 32'd0);
            end else begin
               check32("res_hi", md_if.HI, e.hi);
               check32("res_lo", md_if.LO, e.lo);
               check32("busy_len", busy_cnt, e.cycles);
            end
         end
         busy_cnt = 0;
      end
      prev_busy  = (md_if.Busy === 1'b1);
      prev_reset = reset;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;
      int          sel;
      reset = 1'b1;
      md_if.MDOpE = MD_NONE; md_if.SrcAE = 32'd0; md_if.SrcBE = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check32("rst_busy", {31'd0, md_if.Busy}, 32'd0);
      check32("rst_hi", md_if.HI, 32'd0);
      check32("rst_lo", md_if.LO, 32'd0);
      check32("rst_mdout", md_if.MDOutE, 32'd0);
      check32("rst_start", {31'd0, md_if.Start}, 32'd0);

      // Directed cases.
      issue(MD_MULT,  32'hFFFF_FFFF, 32'd2); wait_idle();
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2); wait_idle();
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2); wait_idle();
      issue(MD_DIVU,  32'd7,         32'd2); wait_idle();
      mt(MD_MTHI, 32'h11); mt(MD_MTLO, 32'h22);
      issue(MD_DIV, 32'h1234_5678, 32'd0); wait_idle();
      mf(MD_MFHI); mf(MD_MFLO);

      // Start and mthi while Busy must be ignored.
      issue(MD_DIV, 32'd100, 32'd7);
      @(posedge clk); #1;
      md_if.MDOpE = MD_MULT; md_if.SrcAE = 32'd9; md_if.SrcBE = 32'd9;
      @(posedge clk); #1;
      md_if.MDOpE = MD_MTHI; md_if.SrcAE = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      md_if.MDOpE = MD_NONE;
      wait_idle();
      mf(MD_MFLO);
      mf(MD_MFHI);

      // Reset in cycle 3 of a mult.
      issue(MD_MULT, 32'd1000, 32'd1000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      check32("rst_mid_busy", {31'd0, md_if.Busy}, 32'd0);
      check32("rst_mid_hi", md_if.HI, 32'd0);
      check32("rst_mid_lo", md_if.LO, 32'd0);
      issue(MD_MULTU, 32'd3, 32'd4); wait_idle();

      // Overflow division, then a back-to-back mult on the first idle cycle.
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      issue(MD_MULT, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      issue(MD_DIVU, 32'hFFFF_FFFF, 32'd0); wait_idle();

      // Unused codes.
      for (int c = 9; c < 16; c++) noop(4'(c));

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         case (sel)
            0: begin issue(MD_MULT,  a, b); wait_idle(); end
            1: begin issue(MD_MULTU, a, b); wait_idle(); end
            2: begin issue(MD_DIV,   a, b); wait_idle(); end
            3: begin issue(MD_DIVU,  a, b); wait_idle(); end
            4: mt(MD_MTHI, a);
            5: mt(MD_MTLO, a);
            6: mf(MD_MFHI);
            7: mf(MD_MFLO);
            8: noop(MD_NONE);
            default: noop(4'(9 + $urandom_range(0, 6)));
         endcase
      end

      repeat (3) @(posedge clk);
      #1 check32("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
